// File: rtl/pe_mac_stream.sv
// Streaming multiply-accumulate processing element.
// Each accepted beat carries LANES unsigned operand pairs. Their products are
// registered, reduced by an adder tree and accumulated over a programmable
// number of beats. The accumulator is then right-shifted, saturated or
// truncated to OUT_W bits, and held on a valid/ready output port.
module pe_mac_stream #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8,
  parameter int LEN_W  = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [LEN_W-1:0]        len_i,
  input  logic [4:0]              shift_i,
  input  logic                    sat_en_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES*DATA_W-1:0] a_vec_i,
  input  logic [LANES*DATA_W-1:0] b_vec_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [OUT_W-1:0]        out_data_o,
  output logic                    ovf_o,
  output logic                    busy_o
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(LANES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_FLUSH,
    S_OUT
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [4:0]         shift_q;
  logic               sat_en_q;
  logic [LEN_W-1:0]   count_q;
  logic               flush_q;
  logic [PROD_W-1:0]  prod_q [LANES];
  logic               prod_vld_q;
  logic [ACC_W-1:0]   acc_q;
  logic [OUT_W-1:0]   out_q;
  logic               ovf_q;

  // Control strobes produced by the next-state logic.
  logic               in_ready;
  logic               accept;
  logic               ld_cfg;
  logic               clr;
  logic               load_out;
  logic               last_beat;

  // Datapath intermediates.
  logic [SUM_W-1:0]   sum;
  logic [ACC_W-1:0]   r;
  logic               ovf_c;
  logic [OUT_W-1:0]   out_c;

  assign last_beat = ((count_q + LEN_W'(1)) == len_q);

  // Next-state and control decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    ld_cfg   = 1'b0;
    clr      = 1'b0;
    load_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          ld_cfg  = 1'b1;
          clr     = 1'b1;
          state_d = (len_i != '0) ? S_ACC : S_FLUSH;
        end
      end
      S_ACC: begin
        in_ready = (count_q < len_q);
        accept   = in_ready && in_valid_i;
        if (accept && last_beat) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // Second flush cycle: the last product has reached acc_q.
        if (flush_q) begin
          load_out = 1'b1;
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, job configuration, beat counter and flush timer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      shift_q  <= '0;
      sat_en_q <= 1'b0;
      count_q  <= '0;
      flush_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      if (ld_cfg) begin
        len_q    <= len_i;
        shift_q  <= shift_i;
        sat_en_q <= sat_en_i;
      end
      if (clr)         count_q <= '0;
      else if (accept) count_q <= count_q + LEN_W'(1);
      flush_q <= (state_q == S_FLUSH) ? ~flush_q : 1'b0;
    end
  end

  // Product stage: one registered product per lane for each accepted beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the product array is small and must read as zero after reset,
      // so it is reset like ordinary flops rather than left as memory.
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      prod_vld_q <= accept;
      if (accept) begin
        for (int i = 0; i < LANES; i++) begin
          prod_q[i] <= PROD_W'(a_vec_i[i*DATA_W +: DATA_W]) *
                       PROD_W'(b_vec_i[i*DATA_W +: DATA_W]);
        end
      end
    end
  end

  // Adder tree reducing the lane products.
  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) sum = sum + SUM_W'(prod_q[i]);
  end

  // Accumulator: cleared on start, wraps modulo 2^ACC_W.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)         acc_q <= '0;
    else if (clr)        acc_q <= '0;
    else if (prod_vld_q) acc_q <= acc_q + ACC_W'(sum);
  end

  // Shift, overflow detect and saturate/truncate.
  always_comb begin
    r     = acc_q >> shift_q;
    ovf_c = |r[ACC_W-1:OUT_W];
    out_c = (ovf_c && sat_en_q) ? {OUT_W{1'b1}} : r[OUT_W-1:0];
  end

  // Result register, loaded once at the end of the flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else if (load_out) begin
      out_q <= out_c;
      ovf_q <= ovf_c;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = (state_q == S_OUT);
  assign out_data_o  = out_q;
  assign ovf_o       = ovf_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule
